// File: rtl/video_dbl_pkg.sv
// video_dbl_pkg: shared defaults and bank-select type for the VGA scan-doubler.
package video_dbl_pkg;
  localparam int DBL_LINE_W = 512;
  localparam int DBL_AW = 9;
  localparam logic [7:0] DBL_SCAN_IDX = 8'h00;
  typedef enum logic {BANK0 = 1'b0, BANK1 = 1'b1} bank_t;
endpackage

// File: rtl/dbl_linebuf.sv
// dbl_linebuf: two-bank line buffer, simple dual-port RAM with a registered read port.
module dbl_linebuf
  import video_dbl_pkg::*;
#(
  parameter int AW = DBL_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW:0]   raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**(AW+1)];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/video_vga_dbl.sv
// video_vga_dbl: captures a TV line into a ping-pong buffer and replays it twice at VGA rate.
// Optional scanline darkening of second replays is built with VIDEO_DBL_SCANLINE_EN.
module video_vga_dbl
  import video_dbl_pkg::*;
#(
  parameter int         LINE_W   = DBL_LINE_W,
  parameter int         AW       = DBL_AW,
  parameter logic [7:0] SCAN_IDX = DBL_SCAN_IDX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tv_line_start,
  input  logic       wr_stb,
  input  logic       tv_de,
  input  logic [7:0] vplex_in,
  input  logic       vga_line_start,
  input  logic       rd_stb,
  input  logic       vga_de,
  input  logic       scanline_on,
  output logic [7:0] vgaplex,
  output logic       vga_line,
  output logic       vga_blank,
  output logic       ovf
);
  localparam logic [AW:0] LW = (AW+1)'(LINE_W);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  bank_t       wr_bank, rd_bank;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] len [2];
  logic        pending, rd_ok, do_wr, do_rd;
  logic [7:0]  rdata;
  assign do_wr = wr_stb & tv_de & (wr_ptr < LW);
  assign do_rd = rd_stb & vga_de;
  dbl_linebuf #(.AW(AW)) u_buf (
    .clk   (clk),
    .we    (do_wr),
    .waddr ({wr_bank, wr_ptr[AW-1:0]}),
    .wdata (vplex_in),
    .re    (do_rd),
    .raddr ({rd_bank, rd_ptr[AW-1:0]}),
    .rdata (rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank   <= BANK0;
      rd_bank   <= BANK1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      len[0]    <= '0;
      len[1]    <= '0;
      pending   <= 1'b0;
      vga_line  <= 1'b0;
      vga_blank <= 1'b1;
      ovf       <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      if (wr_stb & tv_de & ~do_wr) ovf <= 1'b1;
      // a write in the swap clock still lands in, and is counted for, the old bank
      if (tv_line_start) begin
        len[wr_bank] <= wr_ptr + (AW+1)'(do_wr);
        rd_bank      <= wr_bank;
        wr_bank      <= bank_t'(~wr_bank);
        wr_ptr       <= '0;
        pending      <= 1'b1;
      end else if (do_wr) wr_ptr <= wr_ptr + ONE;
      if (vga_line_start) begin
        rd_ptr   <= '0;
        vga_line <= ~(pending | tv_line_start);
        pending  <= 1'b0;
      end else if (do_rd && rd_ptr < LW) rd_ptr <= rd_ptr + ONE;
      if (rd_stb) begin
        vga_blank <= ~vga_de;
        rd_ok     <= vga_de & (rd_ptr < len[rd_bank]);
      end
    end
  end
`ifdef VIDEO_DBL_SCANLINE_EN
  logic scan_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_q <= 1'b0;
    else if (rd_stb) scan_q <= vga_de & scanline_on & vga_line;
  end
  assign vgaplex = scan_q ? SCAN_IDX : rd_ok ? rdata : 8'h00;
`else
  logic unused_scan;
  assign unused_scan = scanline_on;
  assign vgaplex = rd_ok ? rdata : 8'h00;
`endif
endmodule

// File: tb/tb_video_vga_dbl.sv
// tb_video_vga_dbl: directed scoreboard bench for the VGA scan-doubler (default build).
module tb_video_vga_dbl;
  logic clk = 0, rst_n = 0;
  logic tv_line_start = 0, wr_stb = 0, tv_de = 0, vga_line_start = 0, rd_stb = 0, vga_de = 0, scanline_on = 0;
  logic [7:0] vplex_in = 0, vgaplex;
  logic vga_line, vga_blank, ovf;
  int checks = 0, errors = 0;
  logic [8:0] exp_q [$];

  video_vga_dbl dut (
    .clk(clk), .rst_n(rst_n), .tv_line_start(tv_line_start), .wr_stb(wr_stb), .tv_de(tv_de),
    .vplex_in(vplex_in), .vga_line_start(vga_line_start), .rd_stb(rd_stb), .vga_de(vga_de),
    .scanline_on(scanline_on), .vgaplex(vgaplex), .vga_line(vga_line), .vga_blank(vga_blank), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // monitor: a strobe seen at a rising edge must be reflected on the outputs half a clock later
  initial forever begin
    @(posedge clk);
    if (rd_stb) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pix: output with empty scoreboard, got blank=%0b pix=%02h", vga_blank, vgaplex);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({vga_blank, vgaplex} !== e) begin
          errors++;
          $display("FAIL pix: got blank=%0b pix=%02h, expected blank=%0b pix=%02h", vga_blank, vgaplex, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic write_px(input logic [7:0] d);
    wr_stb = 1; tv_de = 1; vplex_in = d;
    @(negedge clk);
    wr_stb = 0; tv_de = 0;
    @(negedge clk);
  endtask

  task automatic tv_start();
    tv_line_start = 1;
    @(negedge clk);
    tv_line_start = 0;
  endtask

  task automatic vga_start(input logic exp_line);
    vga_line_start = 1;
    @(negedge clk);
    vga_line_start = 0;
    chk("vga_line", 16'(vga_line), 16'(exp_line));
  endtask

  task automatic read_px(input logic de, input logic [7:0] exp_pix);
    exp_q.push_back({~de, exp_pix});
    rd_stb = 1; vga_de = de;
    @(negedge clk);
    rd_stb = 0; vga_de = 0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] ovf_px(input int i);
    logic [9:0] v;
    v = 10'(i);
    return v[7:0] ^ {v[9:8], 6'b0};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_vgaplex", 16'(vgaplex), 16'h00);
    chk("rst_blank", 16'(vga_blank), 16'h1);
    chk("rst_line", 16'(vga_line), 16'h0);
    chk("rst_ovf", 16'(ovf), 16'h0);
    rst_n = 1;
    @(negedge clk);
    // basic doubling
    for (int i = 0; i < 16; i++) write_px(8'h10 + 8'(i));
    tv_start();
    vga_start(1'b0);
    for (int i = 0; i < 16; i++) read_px(1'b1, 8'h10 + 8'(i));
    vga_start(1'b1);
    for (int i = 0; i < 16; i++) read_px(1'b1, 8'h10 + 8'(i));
    // short line padded with zeros
    write_px(8'hAA); write_px(8'hBB); write_px(8'hCC); write_px(8'hDD);
    tv_start();
    vga_start(1'b0);
    read_px(1, 8'hAA); read_px(1, 8'hBB); read_px(1, 8'hCC); read_px(1, 8'hDD);
    for (int i = 0; i < 4; i++) read_px(1'b1, 8'h00);
    vga_start(1'b1);
    // third replay with leading blank strobes
    vga_start(1'b1);
    for (int i = 0; i < 3; i++) read_px(1'b0, 8'h00);
    read_px(1, 8'hAA); read_px(1, 8'hBB);
    // coincident starts
    write_px(8'h01); write_px(8'h02); write_px(8'h03);
    tv_line_start = 1; vga_line_start = 1;
    @(negedge clk);
    tv_line_start = 0; vga_line_start = 0;
    chk("coinc_line", 16'(vga_line), 16'h0);
    read_px(1, 8'h01); read_px(1, 8'h02); read_px(1, 8'h03); read_px(1, 8'h00);
    vga_start(1'b1);
    read_px(1, 8'h01);
    // overflow
    for (int i = 0; i < 520; i++) begin
      write_px(ovf_px(i));
      if (i == 511) chk("ovf_at_512", 16'(ovf), 16'h0);
      if (i == 512) chk("ovf_at_513", 16'(ovf), 16'h1);
    end
    tv_start();
    vga_start(1'b0);
    for (int i = 0; i < 512; i++) read_px(1'b1, ovf_px(i));
    read_px(1, 8'h00); read_px(1, 8'h00);
    write_px(8'h44);
    tv_start();
    chk("ovf_sticky", 16'(ovf), 16'h1);
    // reset mid-stream
    rst_n = 0;
    @(negedge clk);
    chk("rst2_ovf", 16'(ovf), 16'h0);
    chk("rst2_blank", 16'(vga_blank), 16'h1);
    rst_n = 1;
    @(negedge clk);
    vga_start(1'b1);
    read_px(1, 8'h00); read_px(1, 8'h00);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs never appeared, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
